// File: rtl/pingpong_input_buffer.sv
// Two-bank ping-pong sample buffer: the producer fills one bank while the
// consumer reads the other; a partially filled bank can be closed by flush.
module pingpong_input_buffer #(
    parameter int  DATA_WIDTH = 12,
    parameter int  BLOCK_SIZE = 256,
    localparam int AW         = $clog2(BLOCK_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    output logic                  ready_in,
    input  logic                  flush,
    output logic                  block_ready,
    output logic [AW:0]           block_len,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    // "release" is a reserved word in SystemVerilog, hence the suffix
    input  logic                  release_bank,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_st_t;

    logic [DATA_WIDTH-1:0] mem [2][BLOCK_SIZE];

    bank_st_t              bank_st_q  [2];
    bank_st_t              bank_st_d  [2];
    logic [AW:0]           bank_len_q [2];
    logic [AW:0]           bank_len_d [2];
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [AW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  ovf_q, ovf_d;

    logic accept;
    logic wr_last;
    logic do_flush;
    logic complete;
    logic do_release;

    always_comb begin
        ready_in    = (bank_st_q[wr_bank_q] != BANK_FULL);
        block_ready = (bank_st_q[rd_bank_q] == BANK_FULL);
        block_len   = block_ready ? bank_len_q[rd_bank_q] : '0;
        accept      = valid_in & ready_in;
        wr_last     = (wr_cnt_q == AW'(BLOCK_SIZE - 1));
        do_flush    = flush & ready_in & ((wr_cnt_q != '0) | accept);
        complete    = (accept & wr_last) | do_flush;
        do_release  = release_bank & block_ready;
    end

    // Release only touches a FULL read bank and completion only a non-FULL
    // write bank, so both may update the two banks in the same cycle.
    always_comb begin
        bank_st_d  = bank_st_q;
        bank_len_d = bank_len_q;
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_bank_d  = rd_bank_q;
        if (accept) begin
            bank_st_d[wr_bank_q] = BANK_FILLING;
            wr_cnt_d             = AW'(wr_cnt_q + 1'b1);
        end
        if (complete) begin
            bank_st_d[wr_bank_q]  = BANK_FULL;
            bank_len_d[wr_bank_q] = (AW+1)'(wr_cnt_q) + (AW+1)'(accept);
            wr_bank_d             = ~wr_bank_q;
            wr_cnt_d              = '0;
        end
        if (do_release) begin
            bank_st_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d            = ~rd_bank_q;
        end
    end

    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en && block_ready) begin
            rd_valid_d = 1'b1;
            rd_data_d  = ({1'b0, rd_addr} < bank_len_q[rd_bank_q]) ?
                         mem[rd_bank_q][rd_addr] : '0;
        end
        ovf_d = (valid_in & ~ready_in) | (ovf_q & ~clear_ovf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                bank_st_q[i]  <= BANK_EMPTY;
                bank_len_q[i] <= '0;
            end
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            bank_st_q  <= bank_st_d;
            bank_len_q <= bank_len_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // Sample storage is not reset; bank state alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank_q][wr_cnt_q] <= sample_in;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pingpong_input_buffer.sv
// Directed bench for pingpong_input_buffer with BLOCK_SIZE = 8, DATA_WIDTH = 12.
module tb_pingpong_input_buffer;

    localparam int DW = 12;
    localparam int BS = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          valid_in;
    logic [DW-1:0] sample_in;
    logic          ready_in;
    logic          flush;
    logic          block_ready;
    logic [AW:0]   block_len;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          release_bank;
    logic          overflow;
    logic          clear_ovf;

    int checks   = 0;
    int failures = 0;

    pingpong_input_buffer #(.DATA_WIDTH(DW), .BLOCK_SIZE(BS)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_in     (valid_in),
        .sample_in    (sample_in),
        .ready_in     (ready_in),
        .flush        (flush),
        .block_ready  (block_ready),
        .block_len    (block_len),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .release_bank (release_bank),
        .overflow     (overflow),
        .clear_ovf    (clear_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          valid;
        logic [DW-1:0] sample;
        logic          flush;
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          rel;
        logic          clr;
        logic          e_ready;
        logic          e_br;
        logic [AW:0]   e_len;
        logic          e_rv;
        logic [DW-1:0] e_data;
        logic          e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic vld, input int smp, input logic fl, input logic re,
                     input int ad, input logic rl, input logic cl,
                     input logic er, input logic ebr, input int elen,
                     input logic erv, input int edata, input logic eovf);
        vec_t t;
        t.valid = vld;  t.sample = DW'(smp); t.flush = fl; t.rd_en = re;
        t.addr  = AW'(ad); t.rel = rl; t.clr = cl;
        t.e_ready = er; t.e_br = ebr; t.e_len = (AW+1)'(elen);
        t.e_rv = erv; t.e_data = DW'(edata); t.e_ovf = eovf;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        valid_in = 0; sample_in = '0; flush = 0; rd_en = 0; rd_addr = '0;
        release_bank = 0; clear_ovf = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic er, input logic ebr,
                              input int elen, input logic erv, input int edata,
                              input logic eovf);
        check({tag, "_ready"}, 32'(ready_in), 32'(er));
        check({tag, "_block_ready"}, 32'(block_ready), 32'(ebr));
        check({tag, "_block_len"}, 32'(block_len), 32'(elen));
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(erv));
        check({tag, "_rd_data"}, 32'(rd_data), 32'(edata));
        check({tag, "_overflow"}, 32'(overflow), 32'(eovf));
    endtask

    task automatic push(input int smp);
        idle();
        valid_in = 1; sample_in = DW'(smp);
        tick();
    endtask

    task automatic rd(input int ad);
        idle();
        rd_en = 1; rd_addr = AW'(ad);
        tick();
    endtask

    task automatic rel();
        idle();
        release_bank = 1;
        tick();
    endtask

    initial begin
        // full block of 1..8, read back, release
        for (int k = 1; k <= 7; k++) v(1, k, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        v(1, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0);
        for (int i = 0; i < 8; i++) v(0, 0, 0, 1, i, 0, 0, 1, 1, 8, 1, i + 1, 0);
        v(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1, 0);
        v(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        // short block of 3 via flush, out-of-range reads return 0
        v(1, 'h11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        v(1, 'h12, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        v(1, 'h13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        v(0, 0, 1, 0, 0, 0, 0, 1, 1, 3, 0, 1, 0);
        v(0, 0, 0, 1, 1, 0, 0, 1, 1, 3, 1, 'h12, 0);
        v(0, 0, 0, 1, 5, 0, 0, 1, 1, 3, 1, 0, 0);
        v(0, 0, 0, 1, 2, 0, 0, 1, 1, 3, 1, 'h13, 0);
        v(0, 0, 0, 1, 3, 0, 0, 1, 1, 3, 1, 0, 0);
        // release coincident with the 8th sample into the other bank
        for (int k = 1; k <= 7; k++) v(1, 'h20 + k, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0, 0);
        v(1, 'h28, 0, 0, 0, 1, 0, 1, 1, 8, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 1, 1, 8, 1, 'h21, 0);
        v(0, 0, 0, 1, 7, 0, 0, 1, 1, 8, 1, 'h28, 0);
        v(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 'h28, 0);
        // empty flush ignored; flush with accept gives a 1-sample block
        v(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 'h28, 0);
        v(1, 'h31, 1, 0, 0, 0, 0, 1, 1, 1, 0, 'h28, 0);
        v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 'h31, 0);
        v(0, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0);
        v(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);

        idle();
        reset = 1;
        tick();
        tick();
        check_outs("reset", 1, 0, 0, 0, 0, 0);
        reset = 0;

        for (int i = 0; i < vq.size(); i++) begin
            valid_in = vq[i].valid; sample_in = vq[i].sample; flush = vq[i].flush;
            rd_en = vq[i].rd_en; rd_addr = vq[i].addr; release_bank = vq[i].rel;
            clear_ovf = vq[i].clr;
            tick();
            check_outs($sformatf("vec%0d", i), vq[i].e_ready, vq[i].e_br,
                       int'(vq[i].e_len), vq[i].e_rv, int'(vq[i].e_data), vq[i].e_ovf);
        end

        // continuous input with no release: both banks fill, then drops
        for (int k = 1; k <= 20; k++) begin
            push(k);
            check($sformatf("stream%0d_ready", k), 32'(ready_in), 32'(k < 16));
            check($sformatf("stream%0d_overflow", k), 32'(overflow), 32'(k > 16));
        end
        idle(); valid_in = 1; sample_in = 'h7ff; clear_ovf = 1; tick();
        check("ovf_set_wins", 32'(overflow), 32'd1);
        idle(); clear_ovf = 1; tick();
        check("ovf_clear", 32'(overflow), 32'd0);
        push('h7fe);
        check("ovf_reset_again", 32'(overflow), 32'd1);
        idle(); clear_ovf = 1; tick();
        check("ovf_clear_again", 32'(overflow), 32'd0);
        rd(0);
        check_outs("full_rd0", 0, 1, 8, 1, 1, 0);
        rel();
        check_outs("full_release", 1, 1, 8, 0, 1, 0);
        rd(0);
        check("bank1_rd0", 32'(rd_data), 32'd9);
        rd(7);
        check("bank1_rd7", 32'(rd_data), 32'd16);
        rel();
        check("bank1_release_br", 32'(block_ready), 32'd0);

        // asynchronous reset in the middle of a fill with a read pending
        for (int k = 1; k <= 8; k++) push('h40 + k);
        for (int k = 1; k <= 5; k++) push('h50 + k);
        rd(2);
        check_outs("pre_reset", 1, 1, 8, 1, 'h43, 0);
        idle();
        #2 reset = 1;
        #1;
        check_outs("async_reset", 1, 0, 0, 0, 0, 0);
        tick();
        check_outs("reset_held", 1, 0, 0, 0, 0, 0);
        reset = 0;
        for (int k = 1; k <= 7; k++) push('h60 + k);
        check("post_reset_7_br", 32'(block_ready), 32'd0);
        push('h68);
        check_outs("post_reset_block", 1, 1, 8, 0, 0, 0);
        rd(0);
        check("post_reset_rd0", 32'(rd_data), 32'h61);
        rd(4);
        check("post_reset_rd4", 32'(rd_data), 32'h65);
        rd(7);
        check_outs("post_reset_rd7", 1, 1, 8, 1, 'h68, 0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
